// File: rtl/chunked_seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding
// and the index-width helper used to size the chunk counter.
package chunked_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a single-chunk counter still has a bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from single-bit full adders;
// also exposes the carry into the top bit for signed-overflow detection.
module addbit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        addbit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout    = c[CHUNK];
    assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock, LS chunk first,
// carrying between cycles, with valid/ready request and response handshakes.
module chunked_seq_adder
    import chunked_seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t state, state_next;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_msb_cin;
    logic             accept;
    logic             last;

    assign accept = req_valid && req_ready;
    assign last   = (idx == LAST_IDX);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a       (a_r[int'(idx)*CHUNK +: CHUNK]),
        .b       (b_r[int'(idx)*CHUNK +: CHUNK]),
        .cin     (c_r),
        .sum     (chunk_sum),
        .cout    (chunk_cout),
        .msb_cin (chunk_msb_cin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = (state == ST_IDLE);
        rsp_valid  = (state == ST_DONE);
        case (state)
            ST_IDLE: if (req_valid)            state_next = ST_BUSY;
            ST_BUSY: if (last)                 state_next = ST_DONE;
            ST_DONE: if (rsp_ready)            state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Subtraction is folded in at accept time: b is inverted and the carry-in
    // flipped, so the BUSY datapath only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
            c_r <= ci ^ sub;
            idx <= '0;
        end else if (state == ST_BUSY) begin
            result[int'(idx)*CHUNK +: CHUNK] <= chunk_sum;
            c_r <= chunk_cout;
            if (last) begin
                carry    <= chunk_cout;
                overflow <= chunk_msb_cin ^ chunk_cout;
                idx      <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
